// File: rtl/prog_seq.sv
// Program sequencer for the 8-bit core: drives prog_ctr into instr_ROM with a req/done run
// handshake, relative/absolute jumps, and call/return through a small hardware return stack.
module prog_seq #(
  parameter int D         = 12,
  parameter int S         = 4,
  parameter int HALT_ADDR = 128
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req,
  input  logic                   stall,
  input  logic                   reljump_en,
  input  logic                   absjump_en,
  input  logic                   call_en,
  input  logic                   ret_en,
  input  logic [D-1:0]           target,
  output logic [D-1:0]           prog_ctr,
  output logic                   running,
  output logic                   done,
  output logic [$clog2(S+1)-1:0] stk_depth,
  output logic                   stk_ovf,
  output logic                   stk_unf
);

  localparam int DW = $clog2(S+1);
  localparam int AW = (S > 1) ? $clog2(S) : 1;
  // A halt address outside the PC range can never match, so the run never completes.
  localparam logic HALT_OK = (64'(HALT_ADDR) < (64'(1) << D));
  localparam logic [D-1:0] HALT_PC = D'(HALT_ADDR);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t         state, state_nxt;
  logic           running_nxt, done_nxt;
  logic [D-1:0]   pc_nxt, pc_inc, stk_top;
  logic [DW-1:0]  depth_nxt;
  logic           ovf_nxt, unf_nxt, push_en, at_halt, start;
  logic [D-1:0]   stk [S];

  function automatic logic [D-1:0] wrap_add(input logic [D-1:0] base,
                                            input logic signed [D-1:0] off);
    logic signed [D:0] sum;
    sum = $signed({1'b0, base}) + $signed({off[D-1], off});
    return sum[D-1:0];
  endfunction

  assign at_halt = (state == RUN) && HALT_OK && (prog_ctr == HALT_PC);
  assign start   = ((state == IDLE) || (state == DONE)) && req;
  assign pc_inc  = prog_ctr + D'(1);
  assign stk_top = stk[AW'(stk_depth - DW'(1))];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      running   <= 1'b0;
      done      <= 1'b0;
      prog_ctr  <= '0;
      stk_depth <= '0;
      stk_ovf   <= 1'b0;
      stk_unf   <= 1'b0;
    end else begin
      state     <= state_nxt;
      running   <= running_nxt;
      done      <= done_nxt;
      prog_ctr  <= pc_nxt;
      stk_depth <= depth_nxt;
      stk_ovf   <= ovf_nxt;
      stk_unf   <= unf_nxt;
    end
  end

  // Stack storage carries no reset: only entries below stk_depth are ever read.
  always_ff @(posedge clk) begin
    if (reset && push_en)
      stk[AW'(stk_depth)] <= pc_inc;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = RUN;
      RUN:     if (at_halt) state_nxt = DONE;
      DONE:    if (req) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    running_nxt = (state_nxt == RUN);
    done_nxt    = (state_nxt == DONE);
  end

  always_comb begin
    pc_nxt    = prog_ctr;
    depth_nxt = stk_depth;
    ovf_nxt   = stk_ovf;
    unf_nxt   = stk_unf;
    push_en   = 1'b0;
    if (start) begin
      pc_nxt    = '0;
      depth_nxt = '0;
      ovf_nxt   = 1'b0;
      unf_nxt   = 1'b0;
    end else if ((state == RUN) && !at_halt && !stall) begin
      // Fixed priority: ret, call, absolute, relative, sequential.
      if (ret_en) begin
        if (stk_depth != '0) begin
          pc_nxt    = stk_top;
          depth_nxt = stk_depth - DW'(1);
        end else begin
          pc_nxt  = pc_inc;
          unf_nxt = 1'b1;
        end
      end else if (call_en) begin
        if (stk_depth < DW'(S)) begin
          push_en   = 1'b1;
          depth_nxt = stk_depth + DW'(1);
        end else begin
          ovf_nxt = 1'b1;
        end
        pc_nxt = target;
      end else if (absjump_en) begin
        pc_nxt = target;
      end else if (reljump_en) begin
        pc_nxt = wrap_add(prog_ctr, $signed(target));
      end else begin
        pc_nxt = pc_inc;
      end
    end
  end

endmodule

// File: tb/tb_prog_seq.sv
// Bench for prog_seq: directed scenarios plus random traffic, all compared every cycle
// against a queue-based behavioural model of the sequencer.
module tb_prog_seq;
  localparam int D = 12;
  localparam int S = 4;
  localparam int HALT = 128;
  localparam int M = 1 << D;

  logic          clk = 1'b0;
  logic          reset, req, stall, reljump_en, absjump_en, call_en, ret_en;
  logic [D-1:0]  target;
  logic [D-1:0]  prog_ctr;
  logic          running, done, stk_ovf, stk_unf;
  logic [$clog2(S+1)-1:0] stk_depth;

  int n_checks = 0;
  int n_fail = 0;

  // reference model state
  int m_mode;          // 0 idle, 1 run, 2 done
  int m_pc;
  int m_stack[$];
  bit m_ovf, m_unf;

  prog_seq #(.D(D), .S(S), .HALT_ADDR(HALT)) dut (
    .clk(clk), .reset(reset), .req(req), .stall(stall),
    .reljump_en(reljump_en), .absjump_en(absjump_en), .call_en(call_en), .ret_en(ret_en),
    .target(target), .prog_ctr(prog_ctr), .running(running), .done(done),
    .stk_depth(stk_depth), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    int off;
    if (!reset) begin
      m_mode = 0; m_pc = 0; m_stack.delete(); m_ovf = 0; m_unf = 0;
    end else if (m_mode != 1) begin
      if (req) begin
        m_mode = 1; m_pc = 0; m_stack.delete(); m_ovf = 0; m_unf = 0;
      end
    end else if (m_pc == HALT) begin
      m_mode = 2;
    end else if (!stall) begin
      if (ret_en) begin
        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
        else begin m_pc = (m_pc + 1) % M; m_unf = 1; end
      end else if (call_en) begin
        if (m_stack.size() < S) m_stack.push_back((m_pc + 1) % M);
        else m_ovf = 1;
        m_pc = int'(target);
      end else if (absjump_en) begin
        m_pc = int'(target);
      end else if (reljump_en) begin
        off = (int'(target) >= M/2) ? int'(target) - M : int'(target);
        m_pc = ((m_pc + off) % M + M) % M;
      end else begin
        m_pc = (m_pc + 1) % M;
      end
    end
  endtask

  task automatic step(input logic rs, input logic rq, input logic st, input logic rl,
                      input logic ab, input logic ca, input logic re, input int tg);
    reset = rs; req = rq; stall = st; reljump_en = rl; absjump_en = ab;
    call_en = ca; ret_en = re; target = D'(tg);
    @(posedge clk);
    model_edge();
    #1;
    chk("prog_ctr", prog_ctr, m_pc);
    chk("running", running, m_mode == 1);
    chk("done", done, m_mode == 2);
    chk("stk_depth", stk_depth, m_stack.size());
    chk("stk_ovf", stk_ovf, m_ovf);
    chk("stk_unf", stk_unf, m_unf);
  endtask

  task automatic idle_step(); step(1, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic start();     step(1, 1, 0, 0, 0, 0, 0, 0); endtask

  initial begin
    int guard;
    if (HALT >= M) $display("note: HALT_ADDR %0d is outside the %0d-bit PC range", HALT, D);
    m_mode = 0; m_pc = 0; m_ovf = 0; m_unf = 0;

    // T1: reset, start, sequential fetch
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1, 1, 1, 7);
    chk("t1_rst_pc", prog_ctr, 0);
    chk("t1_rst_run", running, 0);
    start();
    chk("t1_run", running, 1);
    chk("t1_done", done, 0);
    chk("t1_pc0", prog_ctr, 0);
    idle_step();
    chk("t1_pc1", prog_ctr, 1);
    idle_step();
    chk("t1_pc2", prog_ctr, 2);

    // T2: free run to halt
    guard = 0;
    while (!done && guard < 300) begin idle_step(); guard++; end
    chk("t2_reached_done", done, 1);
    chk("t2_halt_pc", prog_ctr, HALT);
    step(1, 0, 0, 0, 1, 1, 0, 55);
    chk("t2_hold_pc", prog_ctr, HALT);
    start();
    chk("t2_restart_pc", prog_ctr, 0);
    chk("t2_restart_run", running, 1);

    // T3: relative jump back, and PC wrap
    step(1, 0, 0, 0, 1, 0, 0, 10);
    step(1, 0, 0, 1, 0, 0, 0, 12'hFFC);
    chk("t3_rel", prog_ctr, 6);
    step(1, 0, 0, 0, 1, 0, 0, 4095);
    idle_step();
    chk("t3_wrap", prog_ctr, 0);

    // T4: call/ret, underflow
    step(1, 0, 0, 0, 1, 0, 0, 5);
    step(1, 0, 0, 0, 0, 1, 0, 40);
    chk("t4_call_pc", prog_ctr, 40);
    chk("t4_call_depth", stk_depth, 1);
    step(1, 0, 0, 0, 0, 0, 1, 0);
    chk("t4_ret_pc", prog_ctr, 6);
    chk("t4_ret_depth", stk_depth, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0);
    chk("t4_unf_pc", prog_ctr, 7);
    chk("t4_unf", stk_unf, 1);

    // T5: nested calls past capacity, then LIFO unwind
    guard = 0;
    while (!done && guard < 300) begin idle_step(); guard++; end
    start();
    chk("t5_unf_cleared", stk_unf, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 1, 0, 20 + 10*i);
    chk("t5_depth", stk_depth, 4);
    chk("t5_ovf", stk_ovf, 1);
    chk("t5_fifth_jump", prog_ctr, 60);
    step(1, 0, 0, 0, 0, 0, 1, 0); chk("t5_ret1", prog_ctr, 41);
    step(1, 0, 0, 0, 0, 0, 1, 0); chk("t5_ret2", prog_ctr, 31);
    step(1, 0, 0, 0, 0, 0, 1, 0); chk("t5_ret3", prog_ctr, 21);
    step(1, 0, 0, 0, 0, 0, 1, 0); chk("t5_ret4", prog_ctr, 1);
    chk("t5_empty", stk_depth, 0);

    // T6: stall, ret priority, reset mid-run
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, 1, 0, 99);
    chk("t6_stall_pc", prog_ctr, 1);
    chk("t6_stall_depth", stk_depth, 0);
    step(1, 0, 0, 0, 0, 1, 0, 70);
    step(1, 0, 0, 0, 0, 1, 1, 90);
    chk("t6_ret_wins_pc", prog_ctr, 2);
    chk("t6_ret_wins_depth", stk_depth, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_rst_pc", prog_ctr, 0);
    chk("t6_rst_run", running, 0);
    chk("t6_rst_ovf", stk_ovf, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      int tg;
      r = $urandom_range(0, 99);
      tg = ($urandom_range(0, 3) == 0) ? $urandom_range(0, M-1) : $urandom_range(0, 140);
      step(($urandom_range(0, 199) != 0), (r < 30), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), tg);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
